// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults and counter-width helper for the load-use hazard scoreboard
package hazard_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int LOAD_LAT_DEF   = 1;
  localparam int PERF_W_DEF     = 16;

  function automatic int lat_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int LAT_CNT_W_DEF = lat_cnt_w(LOAD_LAT_DEF);
endpackage

// File: rtl/hazard_lat_counter.sv
// rtl/hazard_lat_counter.sv - per-register load latency counter: load, decrement to zero, or hold
module hazard_lat_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);
  // A reload beats the decrement so a newer load restarts the full latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard scoreboard: per-register latency tracking, ID stall and stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  parameter int PERF_W     = PERF_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_is_two_source,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_mem_r_en,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  perf_clr,
  output logic                  hazard_detected,
  output logic                  load_pending,
  output logic [PERF_W-1:0]     perf_stall_cnt
);
  localparam int NREG  = 2 ** REG_ADDR_W;
  localparam int CNT_W = lat_cnt_w(LOAD_LAT);

  logic            issue;
  logic [NREG-1:0] busy;

  assign issue = id_valid & ~hazard_detected & ~freeze & ~flush;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    logic             load;

    // Only loads arm a counter; ALU results are covered by forwarding.
    assign load = issue & id_mem_r_en & (id_dst == REG_ADDR_W'(r)) & (r != 0);

    hazard_lat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .dec_en  (~freeze),
      .load_val(CNT_W'(LOAD_LAT)),
      .cnt     (cnt)
    );

    assign busy[r] = (r != 0) && (cnt != '0);
  end

  assign hazard_detected = ~rst & id_valid &
                           (busy[id_src1] | (id_is_two_source & busy[id_src2]));
  assign load_pending    = |busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
    end else if (hazard_detected && !freeze && !(&perf_stall_cnt)) begin
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench for hazard_scoreboard with LOAD_LAT=1 and LOAD_LAT=3 instances
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_valid, a_two, a_mr, a_freeze, a_flush, a_clr;
  logic [4:0] a_s1, a_s2, a_dst;
  logic       a_haz, a_lp;
  logic [15:0] a_perf;

  logic       b_valid, b_two, b_mr, b_freeze, b_flush, b_clr;
  logic [4:0] b_s1, b_s2, b_dst;
  logic       b_haz, b_lp;
  logic [1:0] b_perf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(1), .PERF_W(16)) u_a (
    .clk(clk), .rst(rst), .id_valid(a_valid), .id_src1(a_s1), .id_src2(a_s2),
    .id_is_two_source(a_two), .id_dst(a_dst), .id_mem_r_en(a_mr),
    .freeze(a_freeze), .flush(a_flush), .perf_clr(a_clr),
    .hazard_detected(a_haz), .load_pending(a_lp), .perf_stall_cnt(a_perf)
  );

  hazard_scoreboard #(.REG_ADDR_W(5), .LOAD_LAT(3), .PERF_W(2)) u_b (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_src1(b_s1), .id_src2(b_s2),
    .id_is_two_source(b_two), .id_dst(b_dst), .id_mem_r_en(b_mr),
    .freeze(b_freeze), .flush(b_flush), .perf_clr(b_clr),
    .hazard_detected(b_haz), .load_pending(b_lp), .perf_stall_cnt(b_perf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic two, input logic [4:0] d, input logic mr);
    a_valid = v; a_s1 = s1; a_s2 = s2; a_two = two; a_dst = d; a_mr = mr;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic two, input logic [4:0] d, input logic mr);
    b_valid = v; b_s1 = s1; b_s2 = s2; b_two = two; b_dst = d; b_mr = mr;
  endtask

  initial begin
    a_freeze = 0; a_flush = 0; a_clr = 0;
    b_freeze = 0; b_flush = 0; b_clr = 0;
    drive_a(1, 5, 5, 1, 5, 1);
    drive_b(1, 7, 7, 1, 7, 1);

    // Reset state with ID inputs that would otherwise matter
    step(); step(); #1;
    chk("rst_a_haz", a_haz, 0);
    chk("rst_a_lp", a_lp, 0);
    chk("rst_a_perf", a_perf, 0);
    chk("rst_b_haz", b_haz, 0);
    chk("rst_b_perf", b_perf, 0);
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    rst = 0;

    // LOAD_LAT=1: load r5 then src1=r5 stalls one cycle
    step(); drive_a(1, 1, 2, 0, 5, 1); #1;
    chk("a_load_haz", a_haz, 0);
    chk("a_load_lp", a_lp, 0);
    step(); drive_a(1, 5, 2, 0, 6, 0); #1;
    chk("a_use_haz", a_haz, 1);
    chk("a_use_lp", a_lp, 1);
    chk("a_use_perf", a_perf, 0);
    step(); #1;
    chk("a_rel_haz", a_haz, 0);
    chk("a_rel_perf", a_perf, 1);
    chk("a_rel_lp", a_lp, 0);

    // Load to r0 never creates a hazard
    step(); drive_a(1, 1, 2, 0, 0, 1);
    step(); drive_a(1, 0, 0, 1, 6, 0); #1;
    chk("r0_haz", a_haz, 0);
    chk("r0_lp", a_lp, 0);

    // Freeze during a stall holds everything for 4 cycles
    step(); drive_a(1, 1, 2, 0, 4, 1);
    step(); drive_a(1, 4, 2, 0, 6, 0); a_freeze = 1; #1;
    chk("frz_haz0", a_haz, 1);
    chk("frz_perf0", a_perf, 1);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("frz_haz", a_haz, 1);
      chk("frz_perf", a_perf, 1);
      chk("frz_lp", a_lp, 1);
    end
    step(); a_freeze = 0; #1;
    chk("unfrz_haz", a_haz, 1);
    chk("unfrz_perf", a_perf, 1);
    step(); #1;
    chk("unfrz_rel_haz", a_haz, 0);
    chk("unfrz_rel_perf", a_perf, 2);

    // perf_clr wins over a same-cycle increment
    step(); drive_a(1, 1, 2, 0, 9, 1);
    step(); drive_a(1, 9, 2, 0, 6, 0); a_clr = 1; #1;
    chk("clr_haz", a_haz, 1);
    step(); a_clr = 0; #1;
    chk("clr_perf", a_perf, 0);
    chk("clr_rel_haz", a_haz, 0);
    step(); drive_a(0, 0, 0, 0, 0, 0);

    // LOAD_LAT=3: two-source reader of r7 stalls three cycles
    step(); drive_b(1, 1, 2, 0, 7, 1); #1;
    chk("b_load_haz", b_haz, 0);
    step(); drive_b(1, 1, 7, 1, 6, 0); #1;
    chk("b_use_haz1", b_haz, 1);
    step(); #1;
    chk("b_use_haz2", b_haz, 1);
    step(); #1;
    chk("b_use_haz3", b_haz, 1);
    step(); #1;
    chk("b_use_rel", b_haz, 0);
    chk("b_use_perf", b_perf, 3);

    // src2 ignored when not a two-source instruction
    step(); drive_b(1, 1, 2, 0, 7, 1);
    step(); drive_b(1, 1, 7, 0, 6, 0); #1;
    chk("b_one_src_haz", b_haz, 0);
    chk("b_one_src_lp", b_lp, 1);
    step(); drive_b(0, 0, 0, 0, 0, 0);
    step(); step(); step(); #1;
    chk("b_drain_lp", b_lp, 0);

    // Back-to-back loads to r3: reload restarts the full latency
    step(); drive_b(1, 1, 2, 0, 3, 1);
    step(); drive_b(1, 1, 2, 0, 3, 1);
    step(); drive_b(1, 3, 2, 0, 6, 0); #1;
    chk("rld_haz1", b_haz, 1);
    step(); #1;
    chk("rld_haz2", b_haz, 1);
    step(); #1;
    chk("rld_haz3", b_haz, 1);
    step(); #1;
    chk("rld_rel", b_haz, 0);
    chk("b_perf_sat", b_perf, 3);
    step(); drive_b(0, 0, 0, 0, 0, 0); b_clr = 1;
    step(); b_clr = 0; #1;
    chk("b_clr_perf", b_perf, 0);

    // Flushed second load does not reload
    step(); drive_b(1, 1, 2, 0, 3, 1);
    step(); b_flush = 1;
    step(); b_flush = 0; drive_b(1, 3, 2, 0, 6, 0); #1;
    chk("fl_haz1", b_haz, 1);
    step(); #1;
    chk("fl_haz2", b_haz, 1);
    step(); #1;
    chk("fl_rel", b_haz, 0);
    chk("fl_perf", b_perf, 2);

    // Reset asserted mid-stall
    step(); drive_b(1, 1, 2, 0, 7, 1);
    step(); drive_b(1, 7, 2, 0, 6, 0); #1;
    chk("mid_haz1", b_haz, 1);
    step(); #1;
    chk("mid_haz2", b_haz, 1);
    chk("mid_perf", b_perf, 3);
    rst = 1; #1;
    chk("mid_rst_haz", b_haz, 0);
    chk("mid_rst_lp", b_lp, 0);
    chk("mid_rst_perf", b_perf, 0);
    chk("mid_rst_a_perf", a_perf, 0);
    step(); rst = 0; #1;
    chk("post_rst_haz", b_haz, 0);
    chk("post_rst_lp", b_lp, 0);
    step(); #1;
    chk("post_rst_haz2", b_haz, 0);
    chk("post_rst_perf", b_perf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-address width; register file holds 2**REG_ADDR_W entries.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal range 1..7: advancing cycles after a load enters EXE before its data is forwardable.
REQ-003 SHALL have parameter PERF_W, default 16: stall-counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as the codebase does.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  ID holds a live instruction.
REQ-008 id_src1, id_src2  in  REG_ADDR_W  ID source registers.
REQ-009 id_is_two_source  in  1  id_src2 is read.
REQ-010 id_dst  in  REG_ADDR_W  ID destination register.
REQ-011 id_mem_r_en  in  1  ID instruction is a load.
REQ-012 freeze  in  1  memory not ready; whole pipeline holds.
REQ-013 flush  in  1  ID instruction is killed this cycle (branch taken).
REQ-014 perf_clr  in  1  synchronous clear of stall counter.
REQ-015 hazard_detected  out  1  stall ID, insert bubble into EXE.
REQ-016 load_pending  out  1  any register has nonzero latency count.
REQ-017 perf_stall_cnt  out  PERF_W  cycles lost to load-use stalls.

Function
REQ-018 SHALL keep one latency counter per register, width clog2(LOAD_LAT+1).
REQ-019 issue = id_valid & ~hazard_detected & ~freeze & ~flush; SHALL be evaluated every cycle.
REQ-020 On issue with id_mem_r_en=1 and id_dst!=0, counter[id_dst] SHALL load LOAD_LAT at the next edge.
REQ-021 When freeze=0, every other nonzero counter SHALL decrement by 1 per edge; when freeze=1, all counters SHALL hold.
REQ-022 If a load issues to a register whose counter is nonzero, the reload SHALL win over the decrement.
REQ-023 busy(r) = (r!=0) & (counter[r]!=0); register 0 SHALL never be busy.
REQ-024 hazard_detected SHALL be combinational: id_valid & (busy(id_src1) | (id_is_two_source & busy(id_src2))).
REQ-025 hazard_detected SHALL not depend on flush or freeze.
REQ-026 With LOAD_LAT=1, a dependent instruction directly behind a load SHALL stall exactly 1 cycle; with LOAD_LAT=N, exactly N cycles (absent freeze).
REQ-027 Non-load writers SHALL never set counters (the forwarding path covers them).
REQ-028 load_pending SHALL be the OR of all busy bits, registered-state only.
REQ-029 perf_stall_cnt SHALL increment when hazard_detected=1 and freeze=0, saturate at all-ones, and clear on perf_clr; perf_clr SHALL win over increment.
REQ-030 flush SHALL not clear counters; loads already past ID complete normally.

Reset
REQ-031 rst=1 SHALL asynchronously clear all counters and perf_stall_cnt to 0; load_pending SHALL read 0.
REQ-032 hazard_detected SHALL read 0 during reset regardless of ID inputs.
REQ-033 Reset asserted mid-stall SHALL drop hazard_detected in the same cycle; no stall state survives deassertion.

Structure
REQ-034 A shared package hazard_pkg SHALL hold REG_ADDR_W and LOAD_LAT defaults and the counter-width constant.
REQ-035 One sub-module, hazard_lat_counter (load / decrement / hold, async reset), SHALL be instantiated per register via generate.

Verification
REQ-036 LOAD_LAT=1: load to r5 issues, next ID reads r5 as src1 -> hazard_detected=1 for 1 cycle, perf_stall_cnt=1.
REQ-037 LOAD_LAT=3: load r7, dependent in ID with is_two_source=1, src2=r7 -> 3 stall cycles; src2=r7 with is_two_source=0 -> no stall.
REQ-038 Load to r0 followed by a reader of r0 -> hazard_detected never asserts.
REQ-039 LOAD_LAT=1, freeze=1 for 4 cycles during the stall -> counter holds, hazard_detected stays 1, perf_stall_cnt unchanged; releases 1 cycle after freeze drops.
REQ-040 Back-to-back loads to r3, second issuing while counter[r3]!=0 -> counter reloads to LOAD_LAT; flush on the second instead -> no reload.
REQ-041 rst pulsed mid-stall with LOAD_LAT=3 -> hazard_detected=0 immediately, load_pending=0, perf_stall_cnt=0.
